axi_lite_cmd_master: RTL

- Upstream AXI4-Lite master that turns a simple command stream (address, data, strobe, read/write) into single AXI4-Lite transactions.
- Drives the AXI-Lite slave port of the register file and returns read data plus response on a response stream.
- Used by control FSMs, test sequencers and UART/debug bridges to reach register banks without implementing the AXI protocol themselves.
- One transaction is outstanding at a time; there is no pipelining across commands.

---
 rtl/axi_lite_cmd_master.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_cmd_master.sv
`default_nettype none
// =============================================================================
// Module   : axi_lite_cmd_master
// Brief    : Turns a command stream into single AXI4-Lite transactions, one at
//            a time. Optional timeout guarded by AXI_CMD_MASTER_TIMEOUT_EN.
// Revision : 1.0
// =============================================================================
module axi_lite_cmd_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  input  logic [ADDR_WIDTH-1:0]     CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]     CMD_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   CMD_WSTRB,
  input  logic                      CMD_WRITE,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  output logic [DATA_WIDTH-1:0]     RSP_RDATA,
  output logic [1:0]                RSP_RESP,
  output logic                      RSP_TIMEOUT,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic                      BUSY,
  output logic [ADDR_WIDTH-1:0]     M_AWADDR,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  input  logic [1:0]                M_BRESP,
  input  logic                      M_BVALID,
  output logic                      M_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_ARADDR,
  output logic                      M_ARVALID,
  input  logic                      M_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_RDATA,
  input  logic [1:0]                M_RRESP,
  input  logic                      M_RVALID,
  output logic                      M_RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  generate
    if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << 20)) begin : g_bad_params
      $error("axi_lite_cmd_master: unsupported parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;

`ifdef AXI_CMD_MASTER_TIMEOUT_EN
  localparam int                TIMER_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  assign RSP_TIMEOUT = rsp_timeout_q;
`else
  assign RSP_TIMEOUT = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
    timer_d       = timer_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          addr_d      = CMD_ADDR;
          wdata_d     = CMD_WDATA;
          wstrb_d     = CMD_WSTRB;
          cmd_ready_d = 1'b0;
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
          timer_d     = '0;
`endif
          if (CMD_WRITE) begin
            state_d   = WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_AW_W: begin
        // AW and W complete independently; B is awaited only after both.
        if (M_AWREADY) awvalid_d = 1'b0;
        if (M_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end
      WR_B: begin
        if (M_BVALID) begin
          rsp_resp_d    = M_BRESP;
          rsp_rdata_d   = '0;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RSP;
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end
      end
      RD_AR: begin
        if (M_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (M_RVALID) begin
          rsp_rdata_d   = M_RDATA;
          rsp_resp_d    = M_RRESP;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RSP;
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end
      end
      RSP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
    // The abort overrides whatever the bus phase was about to do this cycle.
    if (state_q inside {WR_AW_W, WR_B, RD_AR, RD_R}) begin
      timer_d = timer_q + 1'b1;
      if (timer_q == TIMER_LAST) begin
        awvalid_d     = 1'b0;
        wvalid_d      = 1'b0;
        bready_d      = 1'b0;
        arvalid_d     = 1'b0;
        rready_d      = 1'b0;
        rsp_timeout_d = 1'b1;
        rsp_resp_d    = 2'b10;
        rsp_rdata_d   = '0;
        rsp_valid_d   = 1'b1;
        state_d       = RSP;
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
      timer_q       <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
      timer_q       <= timer_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign CMD_READY = cmd_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_RESP  = rsp_resp_q;
  assign BUSY      = (state_q != IDLE);
  assign M_AWADDR  = addr_q;
  assign M_ARADDR  = addr_q;
  assign M_WDATA   = wdata_q;
  assign M_WSTRB   = wstrb_q;
  assign M_AWVALID = awvalid_q;
  assign M_WVALID  = wvalid_q;
  assign M_BREADY  = bready_q;
  assign M_ARVALID = arvalid_q;
  assign M_RREADY  = rready_q;

endmodule
`default_nettype wire
